sram_access_sequencer: RTL and testbench
========================================

Name: sram_access_sequencer

Overview:
Sequences byte-granular accesses from the GPIO-facing request side onto the 32-bit-word SRAM banks. The banks have no byte mask, so a byte write is done as read-modify-write. The block drives precharge, one-hot bank read/write enables, the binary word address (to the word decoder) and the 32-bit write word. It sits between the GPIO request decode and the bank/word-decoder datapath, replacing direct tie-offs of PRE/ReadEn/WriteEn.

Parameters:
ADDR_W, 10, word address width (1024 words per bank)
NUM_BANKS, 4, number of SRAM banks; width of one-hot enables
PRE_CYCLES, 2, cycles sram_pre is held before each access (>=1)
ACC_CYCLES, 2, cycles a read/write enable is held (>=1)

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer idle, request accepted when req_valid&&req_ready
req_write  in  1  1=byte write, 0=byte read
req_bank  in  2  bank select
req_addr  in  ADDR_W  word address
req_byte  in  2  byte lane within word (0=bits 7:0)
req_wdata  in  8  write byte
rsp_valid  out  1  one-cycle pulse, response ready
rsp_rdata  out  8  read byte; for writes, the byte value before the write
rsp_err  out  1  verify mismatch (SRAM_VERIFY_EN only, else 0)
sram_pre  out  1  precharge, active high
bank_read_en  out  NUM_BANKS  one-hot read enable
bank_write_en  out  NUM_BANKS  one-hot write enable
sram_addr  out  ADDR_W  word address to decoder
sram_wdata  out  32  merged write word
bank_rdata  in  NUM_BANKS*32  flattened bank outputs, bank b at [32b+31:32b]

Behaviour:
- Reset (rst==0 at posedge): state IDLE; req_ready=0 while rst low; all other outputs 0; word_q=0.
- Reset mid-operation: abort at the next edge; all enables and sram_pre drop; no rsp_valid.
- States: IDLE -> PRE_R -> RD -> (read) RESP / (write) PRE_W -> WR -> [VPRE -> VRD] -> RESP -> IDLE.
- IDLE: req_ready=1. On handshake, latch write/bank/addr/byte/wdata. Request fields are ignored outside the handshake.
- PRE_R/PRE_W/VPRE: sram_pre=1 for exactly PRE_CYCLES cycles, then advance. Down-counter reloads on each state entry.
- RD/VRD: bank_read_en[bank]=1 for ACC_CYCLES cycles. On the last cycle, capture the bank_rdata slice into word_q (VRD captures into a separate verify register).
- Merge (end of RD): merged = word_q with lane req_byte replaced by wdata. Other lanes are unchanged.
- WR: bank_write_en[bank]=1 for ACC_CYCLES cycles; sram_wdata=merged throughout. sram_wdata is 0 outside WR.
- RESP: rsp_valid=1 for one cycle; rsp_rdata = word_q lane req_byte; return to IDLE. A new request can be accepted on the cycle after RESP.
- sram_addr holds the latched address from PRE_R through RESP; it returns to 0 in IDLE.
- Invariants: at most one bit of the enables is set; read and write enables are never both active; sram_pre never overlaps an enable.
- Latency (defaults), handshake at cycle T:
  - read: rsp_valid at T+5
  - write: rsp_valid at T+9
  - write with verify: rsp_valid at T+13
- req_valid while busy: held off (req_ready=0) with no loss; the requester must hold its fields.
- Every ADDR_W value is valid; the address wraps naturally with no range error.

Optional Feature:
SRAM_VERIFY_EN
- Defined: after WR, run VPRE+VRD on the same address and compare the read-back word with merged. On mismatch, rsp_err=1 together with rsp_valid.
- Undefined: VPRE/VRD are not built; WR goes directly to RESP; rsp_err is tied 0.

Decomposition:
- Shared header/package sram_ctrl_pkg holds:
  - state encodings (IDLE..RESP, 3-bit)
  - default PRE_CYCLES/ACC_CYCLES
  - BYTE_W=8, WORD_W=32
- One sub-module, sram_byte_merge (pure combinational): inputs word, lane, byte; outputs merged word and the extracted old byte. The same module serves the read lane select and the write merge.

Test Plan:
1. Reset: hold rst=0 for 3 cycles during an active WR -> next edge all enables 0, sram_pre=0, req_ready=0, no rsp_valid. Release rst -> req_ready=1.
2. Read: bank 1 holds 0xA1B2C3D4 at addr 0x3FF; read byte 2 -> sram_pre high cycles T+1..T+2, bank_read_en=4'b0010 at T+3..T+4, rsp_valid at T+5 with rsp_rdata=0xB2.
3. Byte write: bank 0 addr 0x005 holds 0x11223344; write byte 0 = 0xEE -> bank_write_en=4'b0001 at T+7..T+8, sram_wdata=0x112233EE, rsp_rdata=0x44 at T+9.
4. Back-to-back: two reads issued with req_valid held -> second handshake exactly one cycle after the first RESP. Fields stay stable; no overlap of enables.
5. Verify (SRAM_VERIFY_EN): model corrupts the bit 31 write -> rsp_err=1 at T+13. With a correct model, rsp_err=0.
6. Parameters PRE_CYCLES=1, ACC_CYCLES=3: read -> rsp_valid at T+5, with the enable width 3 cycles.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared widths, timing defaults and state encodings for the SRAM access sequencer
package sram_ctrl_pkg;
   localparam int BYTE_W         = 8;
   localparam int WORD_W         = 32;
   localparam int DEF_PRE_CYCLES = 2;
   localparam int DEF_ACC_CYCLES = 2;
   localparam int CNT_W          = 8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PRE_R = 3'd1,
      ST_RD    = 3'd2,
      ST_PRE_W = 3'd3,
      ST_WR    = 3'd4,
      ST_VPRE  = 3'd5,
      ST_VRD   = 3'd6,
      ST_RESP  = 3'd7
   } state_t;
endpackage

// File: rtl/sram_byte_merge.sv
// rtl/sram_byte_merge.sv - replaces one byte lane of a word and returns the byte it held
module sram_byte_merge
   import sram_ctrl_pkg::*;
(
   input  logic [WORD_W-1:0] i_word,
   input  logic [1:0]        i_lane,
   input  logic [BYTE_W-1:0] i_byte,
   output logic [WORD_W-1:0] o_merged,
   output logic [BYTE_W-1:0] o_old_byte
);
   always_comb begin
      o_merged                            = i_word;
      o_merged[i_lane*BYTE_W +: BYTE_W]   = i_byte;
      o_old_byte                          = i_word[i_lane*BYTE_W +: BYTE_W];
   end
endmodule

// File: rtl/sram_access_sequencer.sv
// rtl/sram_access_sequencer.sv - byte read / read-modify-write sequencer onto 32-bit SRAM banks
// Optional write read-back check enabled by defining SRAM_VERIFY_EN.
module sram_access_sequencer
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int NUM_BANKS  = 4,
   parameter int PRE_CYCLES = DEF_PRE_CYCLES,
   parameter int ACC_CYCLES = DEF_ACC_CYCLES
)
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [1:0]                  req_bank,
   input  logic [ADDR_W-1:0]           req_addr,
   input  logic [1:0]                  req_byte,
   input  logic [BYTE_W-1:0]           req_wdata,
   output logic                        rsp_valid,
   output logic [BYTE_W-1:0]           rsp_rdata,
   output logic                        rsp_err,
   output logic                        sram_pre,
   output logic [NUM_BANKS-1:0]        bank_read_en,
   output logic [NUM_BANKS-1:0]        bank_write_en,
   output logic [ADDR_W-1:0]           sram_addr,
   output logic [WORD_W-1:0]           sram_wdata,
   input  logic [NUM_BANKS*WORD_W-1:0] bank_rdata
);
   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_load;
   logic                r_write;
   logic [1:0]          r_bank;
   logic [ADDR_W-1:0]   r_addr;
   logic [1:0]          r_byte;
   logic [BYTE_W-1:0]   r_wdata;
   logic [WORD_W-1:0]   r_word_q;
   logic [WORD_W-1:0]   w_slice;
   logic [WORD_W-1:0]   w_merged;
   logic [BYTE_W-1:0]   w_old_byte;
   logic [NUM_BANKS-1:0] w_bank_oh;
   logic                w_last;
`ifdef SRAM_VERIFY_EN
   logic [WORD_W-1:0]   r_verify_q;
`endif

   assign w_slice   = bank_rdata[int'(r_bank)*WORD_W +: WORD_W];
   assign w_bank_oh = NUM_BANKS'(1) << r_bank;
   assign w_last    = (r_cnt == '0);

   // One merge unit serves both the response lane select and the write word.
   sram_byte_merge u_merge (
      .i_word     (r_word_q),
      .i_lane     (r_byte),
      .i_byte     (r_wdata),
      .o_merged   (w_merged),
      .o_old_byte (w_old_byte)
   );

   always_comb begin
      w_state_next  = r_state;
      req_ready     = 1'b0;
      rsp_valid     = 1'b0;
      rsp_rdata     = '0;
      rsp_err       = 1'b0;
      sram_pre      = 1'b0;
      bank_read_en  = '0;
      bank_write_en = '0;
      sram_addr     = r_addr;
      sram_wdata    = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = rst;
            sram_addr = '0;
            if (req_valid) w_state_next = ST_PRE_R;
         end
         ST_PRE_R: begin
            sram_pre = 1'b1;
            if (w_last) w_state_next = ST_RD;
         end
         ST_RD: begin
            bank_read_en = w_bank_oh;
            if (w_last) w_state_next = r_write ? ST_PRE_W : ST_RESP;
         end
         ST_PRE_W: begin
            sram_pre = 1'b1;
            if (w_last) w_state_next = ST_WR;
         end
         ST_WR: begin
            bank_write_en = w_bank_oh;
            sram_wdata    = w_merged;
`ifdef SRAM_VERIFY_EN
            if (w_last) w_state_next = ST_VPRE;
`else
            if (w_last) w_state_next = ST_RESP;
`endif
         end
`ifdef SRAM_VERIFY_EN
         ST_VPRE: begin
            sram_pre = 1'b1;
            if (w_last) w_state_next = ST_VRD;
         end
         ST_VRD: begin
            bank_read_en = w_bank_oh;
            if (w_last) w_state_next = ST_RESP;
         end
`endif
         ST_RESP: begin
            rsp_valid    = 1'b1;
            rsp_rdata    = w_old_byte;
`ifdef SRAM_VERIFY_EN
            rsp_err      = (r_verify_q != w_merged);
`endif
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      w_cnt_load = '0;
      case (w_state_next)
         ST_PRE_R, ST_PRE_W, ST_VPRE: w_cnt_load = CNT_W'(PRE_CYCLES - 1);
         ST_RD, ST_WR, ST_VRD:        w_cnt_load = CNT_W'(ACC_CYCLES - 1);
         default:                     w_cnt_load = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_write  <= 1'b0;
         r_bank   <= '0;
         r_addr   <= '0;
         r_byte   <= '0;
         r_wdata  <= '0;
         r_word_q <= '0;
`ifdef SRAM_VERIFY_EN
         r_verify_q <= '0;
`endif
      end else begin
         r_state <= w_state_next;
         // Each phase counts down from its own length, reloaded on entry.
         if (w_state_next != r_state) r_cnt <= w_cnt_load;
         else if (!w_last)            r_cnt <= r_cnt - 1'b1;
         if (r_state == ST_IDLE && req_valid) begin
            r_write <= req_write;
            r_bank  <= req_bank;
            r_addr  <= req_addr;
            r_byte  <= req_byte;
            r_wdata <= req_wdata;
         end
         if (r_state == ST_RD && w_last) r_word_q <= w_slice;
`ifdef SRAM_VERIFY_EN
         if (r_state == ST_VRD && w_last) r_verify_q <= w_slice;
`endif
      end
   end
endmodule

// File: tb/tb_sram_access_sequencer.sv
// tb/tb_sram_access_sequencer.sv - directed vector bench for sram_access_sequencer
module tb_sram_access_sequencer;
   localparam int NB = 4;
`ifdef SRAM_VERIFY_EN
   localparam bit VERIFY = 1'b1;
   localparam int WR_LAT = 13;
`else
   localparam bit VERIFY = 1'b0;
   localparam int WR_LAT = 9;
`endif

   typedef struct packed {
      logic        write;
      logic [1:0]  bank;
      logic [9:0]  addr;
      logic [1:0]  lane;
      logic [7:0]  wdata;
      logic [7:0]  exp_rdata;
      logic [31:0] exp_word;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, req_valid, req_valid_p, req_write;
   logic [1:0]    req_bank, req_byte;
   logic [9:0]    req_addr;
   logic [7:0]    req_wdata;
   logic          req_ready, rsp_valid, rsp_err, sram_pre;
   logic [7:0]    rsp_rdata;
   logic [NB-1:0] bank_read_en, bank_write_en;
   logic [9:0]    sram_addr;
   logic [31:0]   sram_wdata;
   logic          req_ready_p, rsp_valid_p, rsp_err_p, sram_pre_p;
   logic [7:0]    rsp_rdata_p;
   logic [NB-1:0] bank_read_en_p, bank_write_en_p;
   logic [9:0]    sram_addr_p;
   logic [31:0]   sram_wdata_p;
   logic [NB*32-1:0] bank_rdata, bank_rdata_p;
   logic [31:0]   mem [4][1024];
   bit            corrupt;
   int            vectors, miscompares, inv_fail;
   vec_t          tbl [8];

   sram_access_sequencer u_dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_bank(req_bank), .req_addr(req_addr),
      .req_byte(req_byte), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .sram_pre(sram_pre),
      .bank_read_en(bank_read_en), .bank_write_en(bank_write_en),
      .sram_addr(sram_addr), .sram_wdata(sram_wdata), .bank_rdata(bank_rdata)
   );

   sram_access_sequencer #(.PRE_CYCLES(1), .ACC_CYCLES(3)) u_dut_p (
      .clk(clk), .rst(rst), .req_valid(req_valid_p), .req_ready(req_ready_p),
      .req_write(req_write), .req_bank(req_bank), .req_addr(req_addr),
      .req_byte(req_byte), .req_wdata(req_wdata), .rsp_valid(rsp_valid_p),
      .rsp_rdata(rsp_rdata_p), .rsp_err(rsp_err_p), .sram_pre(sram_pre_p),
      .bank_read_en(bank_read_en_p), .bank_write_en(bank_write_en_p),
      .sram_addr(sram_addr_p), .sram_wdata(sram_wdata_p), .bank_rdata(bank_rdata_p)
   );

   always_comb begin
      for (int b = 0; b < NB; b++) begin
         bank_rdata[32*b +: 32]   = mem[b][sram_addr];
         bank_rdata_p[32*b +: 32] = mem[b][sram_addr_p];
      end
   end

   // Bank model: preload while in reset, corrupt flips bit 31 of every write.
   always @(posedge clk) begin
      if (!rst) begin
         mem[1][10'h3FF] <= 32'hA1B2C3D4;
         mem[0][10'h005] <= 32'h11223344;
         mem[2][10'h000] <= 32'hDEADBEEF;
         mem[3][10'h155] <= 32'h01234567;
      end else begin
         for (int b = 0; b < NB; b++)
            if (bank_write_en[b])
               mem[b][sram_addr] <= corrupt ? (sram_wdata ^ 32'h8000_0000) : sram_wdata;
      end
   end

   always @(negedge clk) begin
      if ($countones(bank_read_en) > 1 || $countones(bank_write_en) > 1 ||
          (bank_read_en != 0 && bank_write_en != 0) ||
          (sram_pre && (bank_read_en != 0 || bank_write_en != 0)))
         inv_fail++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic wait_ready(input bit use_p, output bit ok);
      int n = 0;
      while (!(use_p ? req_ready_p : req_ready) && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = use_p ? req_ready_p : req_ready;
   endtask

   task automatic set_fields(input vec_t v);
      req_write = v.write;
      req_bank  = v.bank;
      req_addr  = v.addr;
      req_byte  = v.lane;
      req_wdata = v.wdata;
   endtask

   task automatic do_txn(input int idx, input vec_t v, input logic exp_err);
      int          lat;
      bit          ok, bad;
      int          bad_k;
      logic [63:0] a, e, bad_a, bad_e;
      logic [7:0]  got_rd;
      logic        got_err, xp;
      logic [3:0]  oh, xrd, xwr;
      lat = v.write ? WR_LAT : 5;
      oh  = 4'b0001 << v.bank;
      set_fields(v);
      req_valid = 1'b1;
      wait_ready(1'b0, ok);
      if (!ok) begin
         chk("handshake_timeout", 32'(ok), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      bad = 1'b0; bad_k = 0; bad_a = '0; bad_e = '0; got_rd = '0; got_err = 1'b0;
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge clk);
         xp  = (k <= 2) || (v.write && (k == 5 || k == 6)) ||
               (VERIFY && v.write && (k == 9 || k == 10));
         xrd = ((k == 3 || k == 4) || (VERIFY && v.write && (k == 11 || k == 12))) ? oh : 4'b0;
         xwr = (v.write && (k == 7 || k == 8)) ? oh : 4'b0;
         a = {11'b0, sram_pre, bank_read_en, bank_write_en, rsp_valid, req_ready, sram_addr, sram_wdata};
         e = {11'b0, xp, xrd, xwr, (k == lat), (k == lat + 1),
              (k <= lat) ? v.addr : 10'h0, (xwr != 0) ? v.exp_word : 32'h0};
         if (a !== e && !bad) begin
            bad = 1'b1; bad_k = k; bad_a = a; bad_e = e;
         end
         if (k == lat) begin
            got_rd  = rsp_rdata;
            got_err = rsp_err;
         end
      end
      vectors++;
      if (bad) begin
         miscompares++;
         $display("FAIL profile vec %0d cycle %0d: got %h, required %h", idx, bad_k, bad_a, bad_e);
      end
      chk($sformatf("rdata_vec%0d", idx), 32'(got_rd), 32'(v.exp_rdata));
      chk($sformatf("rsp_err_vec%0d", idx), 32'(got_err), 32'(exp_err));
   endtask

   initial begin
      int   n;
      bit   ok, seen;
      vec_t vv;
      rst = 1'b0; req_valid = 1'b0; req_valid_p = 1'b0; corrupt = 1'b0;
      req_write = 1'b0; req_bank = '0; req_addr = '0; req_byte = '0; req_wdata = '0;
      vectors = 0; miscompares = 0; inv_fail = 0;
      tbl[0] = '{1'b0, 2'd1, 10'h3FF, 2'd2, 8'h00, 8'hB2, 32'hA1B2C3D4};
      tbl[1] = '{1'b1, 2'd0, 10'h005, 2'd0, 8'hEE, 8'h44, 32'h112233EE};
      tbl[2] = '{1'b0, 2'd0, 10'h005, 2'd0, 8'h00, 8'hEE, 32'h112233EE};
      tbl[3] = '{1'b1, 2'd2, 10'h000, 2'd3, 8'h5A, 8'hDE, 32'h5AADBEEF};
      tbl[4] = '{1'b1, 2'd3, 10'h155, 2'd1, 8'hFF, 8'h45, 32'h0123FF67};
      tbl[5] = '{1'b0, 2'd3, 10'h155, 2'd1, 8'h00, 8'hFF, 32'h0123FF67};
      tbl[6] = '{1'b0, 2'd2, 10'h000, 2'd3, 8'h00, 8'h5A, 32'h5AADBEEF};
      tbl[7] = '{1'b1, 2'd1, 10'h3FF, 2'd2, 8'h00, 8'hB2, 32'hA100C3D4};

      repeat (3) @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_outs", 32'({sram_pre, bank_read_en, bank_write_en, rsp_valid, rsp_err, rsp_rdata}), 32'd0);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_wdata", sram_wdata, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(req_ready), 32'd1);

      for (int i = 0; i < 8; i++) begin
         do_txn(i, tbl[i], 1'b0);
         chk($sformatf("mem_word_vec%0d", i), mem[tbl[i].bank][tbl[i].addr], tbl[i].exp_word);
      end

      // Back-to-back reads with req_valid held; fields change only after the first handshake.
      vv = '{1'b0, 2'd1, 10'h3FF, 2'd0, 8'h00, 8'hD4, 32'h0};
      set_fields(vv);
      req_valid = 1'b1;
      wait_ready(1'b0, ok);
      @(posedge clk);
      #1 vv = '{1'b0, 2'd0, 10'h005, 2'd3, 8'h00, 8'h11, 32'h0};
      set_fields(vv);
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
      chk("b2b_lat1", 32'(n), 32'd5);
      chk("b2b_rd1", 32'(rsp_rdata), 32'hD4);
      @(negedge clk);
      chk("b2b_gap_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
      chk("b2b_lat2", 32'(n), 32'd5);
      chk("b2b_rd2", 32'(rsp_rdata), 32'h11);
      @(negedge clk);

      // PRE_CYCLES=1, ACC_CYCLES=3 instance: same T+5 latency, three-cycle enable.
      vv = '{1'b0, 2'd2, 10'h000, 2'd3, 8'h00, 8'h5A, 32'h0};
      set_fields(vv);
      req_valid_p = 1'b1;
      wait_ready(1'b1, ok);
      @(posedge clk);
      #1 req_valid_p = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         chk($sformatf("param_k%0d", k),
             {rsp_err_p, (sram_wdata_p != 0), sram_pre_p, bank_read_en_p, bank_write_en_p, rsp_valid_p, req_ready_p},
             {2'b00, (k == 1), (k >= 2 && k <= 4) ? 4'b0100 : 4'b0000, 4'b0000, (k == 5), (k == 6)});
         if (k == 5) chk("param_rdata", 32'(rsp_rdata_p), 32'h5A);
      end

`ifdef SRAM_VERIFY_EN
      corrupt = 1'b1;
      vv = '{1'b1, 2'd0, 10'h005, 2'd1, 8'h77, 8'h33, 32'h112277EE};
      do_txn(100, vv, 1'b1);
      corrupt = 1'b0;
      chk("verify_mem", mem[0][10'h005], 32'h912277EE);
`endif

      // Reset while the write enable is active.
      vv = '{1'b1, 2'd3, 10'h155, 2'd0, 8'h11, 8'h00, 32'h0};
      set_fields(vv);
      req_valid = 1'b1;
      wait_ready(1'b0, ok);
      @(posedge clk);
      #1 req_valid = 1'b0;
      n = 0;
      while (bank_write_en == 0 && n < 30) begin @(negedge clk); n++; end
      chk("reach_wr", 32'(bank_write_en != 0), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_en", 32'({sram_pre, bank_read_en, bank_write_en}), 32'd0);
      chk("abort_ready", 32'(req_ready), 32'd0);
      chk("abort_addr", 32'(sram_addr), 32'd0);
      seen = rsp_valid;
      repeat (2) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      chk("no_rsp_in_rst", 32'(seen), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_release", 32'(req_ready), 32'd1);

      chk("invariants", 32'(inv_fail), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
